iter_shifter_v2: RTL and testbench

- Parametrised successor to the ALU2 iterative shifter.
- Performs SRL/SRA/SLL plus ROR/ROL on an XLEN-bit operand, shifting at most STEP bits per cycle to keep the ALU2 critical path short.
- Adds explicit busy/flush handshaking, a finish-in-last-step policy (no trailing idle cycle) and a single-cycle done pulse.
- Sits in ALU2 alongside the multiplier/divider; the issue logic drives start/flush and consumes data_out on done.

---
 rtl/iter_shifter_v2_if.sv | 26 ++
 rtl/iter_shifter_v2.sv | 127 ++++++++++++
 tb/tb_iter_shifter_v2.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/iter_shifter_v2_if.sv
// Issue-side handshake and operand bus for the ALU2 iterative shifter.
// The master (issue logic) drives start/flush and the operand, the slave
// (shifter) returns busy, done and the result.
interface iter_shifter_v2_if #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
);
  logic               start;
  logic [2:0]         op;
  logic [XLEN-1:0]    data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               flush;
  logic               busy;
  logic [XLEN-1:0]    data_out;
  logic               done;

  modport master (
    output start, op, data_in, shamt, flush,
    input  busy, data_out, done
  );

  modport slave (
    input  start, op, data_in, shamt, flush,
    output busy, data_out, done
  );
endinterface

// File: rtl/iter_shifter_v2.sv
// Iterative SRL/SRA/SLL/ROR/ROL shifter for ALU2.
// Shifts at most STEP bits per cycle and finishes in the cycle of the last
// step, raising a one-cycle done pulse together with the result.
// Optional build macro ITER_SHIFTER_COARSE_EN adds an 8-bit coarse step that
// is taken whenever at least 8 bits remain; results are unchanged.
module iter_shifter_v2 #(
  parameter int XLEN    = 32,
  parameter int STEP    = 3,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input logic             clk,
  input logic             rst_n,
  iter_shifter_v2_if.slave bus
);

  // Remaining count and step size carry one extra bit so that XLEN itself
  // fits when forming the complementary rotate distance.
  localparam int RW = SHAMT_W + 1;
  localparam logic [RW-1:0] STEP_W = RW'(STEP);
  localparam logic [RW-1:0] XLEN_W = RW'(XLEN);
`ifdef ITER_SHIFTER_COARSE_EN
  localparam int COARSE = 8;
  localparam logic [RW-1:0] COARSE_W = RW'(COARSE);
`endif

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] data_out_q, data_out_d;
  logic            done_q, done_d;

  logic [RW-1:0]   step;
  logic [XLEN-1:0] shifted;

  // One shift of 'a' by 's' bits; reserved op codes pass the operand through.
  function automatic logic [XLEN-1:0] shift_f(input logic [XLEN-1:0] a,
                                              input logic [2:0]      o,
                                              input logic [RW-1:0]   s);
    logic [RW-1:0]   inv;
    logic [XLEN-1:0] res;
    inv = XLEN_W - s;
    case (o)
      3'b000:  res = a >> s;
      3'b001:  res = $unsigned($signed(a) >>> s);
      3'b010:  res = a << s;
      3'b011:  res = (a >> s) | (a << inv);
      3'b100:  res = (a << s) | (a >> inv);
      default: res = a;
    endcase
    return res;
  endfunction

  // Per-cycle step size: coarse jump when enough bits remain, else fine step.
  always_comb begin
    step = (rem_q < STEP_W) ? rem_q : STEP_W;
`ifdef ITER_SHIFTER_COARSE_EN
    if (rem_q >= COARSE_W) begin
      step = COARSE_W;
    end
`endif
    shifted = shift_f(acc_q, op_q, step);
  end

  // Next-state, datapath update and completion logic.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    op_d       = op_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          acc_d   = bus.data_in;
          rem_d   = (bus.op > 3'b100) ? '0 : {1'b0, bus.shamt};
          op_d    = bus.op;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = shifted;
          rem_d = rem_q - step;
          if (rem_q == step) begin
            data_out_d = shifted;
            done_d     = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      rem_q      <= '0;
      op_q       <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      op_q       <= op_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = (state_q == SHIFT);
  assign bus.data_out = data_out_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_iter_shifter_v2.sv
// Self-checking bench for iter_shifter_v2 (XLEN=32, STEP=3): directed table,
// multi-cycle corner sequences and randomized ops against a reference model.
module tb_iter_shifter_v2;

  localparam int XLEN = 32;
  localparam int STEP = 3;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  iter_shifter_v2_if #(.XLEN(XLEN)) bus ();

  iter_shifter_v2 #(.XLEN(XLEN), .STEP(STEP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] data;
    int          shamt;
    logic [31:0] exp_data;
    int          exp_n_fine;
    int          exp_n_coarse;
  } vec_t;

  vec_t vecs[9];

  // Reference result computed on a doubled operand for rotates.
  function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] d, input int sh);
    logic [63:0] dd;
    logic [63:0] t;
    dd = {d, d};
    case (op)
      3'd0:    return d >> sh;
      3'd1:    return $unsigned($signed(d) >>> sh);
      3'd2:    return d << sh;
      3'd3:    begin t = dd >> sh; return t[31:0]; end
      3'd4:    begin t = dd << sh; return t[63:32]; end
      default: return d;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input int sh);
    int n;
    if (op > 3'd4) return 1;
`ifdef ITER_SHIFTER_COARSE_EN
    n = sh / 8 + ((sh % 8) + STEP - 1) / STEP;
`else
    n = (sh + STEP - 1) / STEP;
`endif
    return (n < 1) ? 1 : n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents one request and returns just after the accepting edge.
  task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] d, input int sh);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.data_in = d;
    bus.shamt   = 5'(sh);
    tick();
    bus.start = 1'b0;
    checkOutput({name, " busy after accept"}, 32'(bus.busy), 32'd1);
    checkOutput({name, " done low after accept"}, 32'(bus.done), 32'd0);
  endtask

  // Waits (bounded) for done; optionally pokes a start while busy.
  task automatic waitDone(input string name, input logic [31:0] exp, input int exp_n, input int intrude_at);
    int edges = 0;
    int busy_cycles = 1;
    bit got = 0;
    while (!got && edges < 40) begin
      if (intrude_at > 0 && edges == intrude_at) begin
        bus.start   = 1'b1;
        bus.op      = 3'd0;
        bus.data_in = 32'hFFFF_FFFF;
        bus.shamt   = 5'd1;
      end
      tick();
      edges++;
      bus.start = 1'b0;
      if (bus.done) got = 1;
      else if (bus.busy) busy_cycles++;
    end
    if (!got) begin
      checkOutput({name, " done timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({name, " latency"}, 32'(edges), 32'(exp_n));
      checkOutput({name, " busy cycles"}, 32'(busy_cycles), 32'(exp_n));
      checkOutput({name, " busy low at done"}, 32'(bus.busy), 32'd0);
      checkOutput({name, " data_out"}, bus.data_out, exp);
    end
  endtask

  initial begin
    logic [31:0] prev;
    int          done_seen;
    logic [2:0]  r_op;
    logic [31:0] r_data;
    int          r_sh;

    vecs[0] = '{"sra_sign",  3'd1, 32'h8000_0000, 4,  32'hF800_0000, 2,  2};
    vecs[1] = '{"sll_31",    3'd2, 32'h0000_0001, 31, 32'h8000_0000, 11, 6};
    vecs[2] = '{"ror_1",     3'd3, 32'h0000_0001, 1,  32'h8000_0000, 1,  1};
    vecs[3] = '{"rol_8",     3'd4, 32'h8000_0001, 8,  32'h0000_0180, 3,  1};
    vecs[4] = '{"srl_0",     3'd0, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF, 1,  1};
    vecs[5] = '{"rsvd_pass", 3'd5, 32'h1234_5678, 9,  32'h1234_5678, 1,  1};
    vecs[6] = '{"sra_31",    3'd1, 32'h7FFF_FFFF, 31, 32'h0000_0000, 11, 6};
    vecs[7] = '{"ror_16",    3'd3, 32'h1234_5678, 16, 32'h5678_1234, 6,  2};
    vecs[8] = '{"srl_20",    3'd0, 32'hFFFF_FFFF, 20, 32'h0000_0FFF, 7,  4};

    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.flush   = 1'b0;
    bus.op      = 3'd0;
    bus.data_in = '0;
    bus.shamt   = '0;
    #12;
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset data_out", bus.data_out, 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed table, issued back-to-back.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].name, vecs[i].op, vecs[i].data, vecs[i].shamt);
`ifdef ITER_SHIFTER_COARSE_EN
      waitDone(vecs[i].name, vecs[i].exp_data, vecs[i].exp_n_coarse, 0);
`else
      waitDone(vecs[i].name, vecs[i].exp_data, vecs[i].exp_n_fine, 0);
`endif
    end

    // Start while busy is ignored.
    applyStimulus("sll_intrude", 3'd2, 32'h0000_0001, 31);
    waitDone("sll_intrude", 32'h8000_0000, ref_latency(3'd2, 31), 4);
    tick();
    checkOutput("intrude no extra op", 32'(bus.busy), 32'd0);

    // Explicit back-to-back: second start in the done cycle.
    applyStimulus("b2b_first", 3'd0, 32'hDEAD_BEEF, 0);
    waitDone("b2b_first", 32'hDEAD_BEEF, 1, 0);
    applyStimulus("b2b_second", 3'd4, 32'h8000_0001, 8);
    waitDone("b2b_second", 32'h0000_0180, ref_latency(3'd4, 8), 0);
    prev = 32'h0000_0180;

    // Flush mid-operation.
    applyStimulus("flush_mid", 3'd0, 32'hFFFF_FFFF, 20);
    tick();
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checkOutput("flush_mid busy", 32'(bus.busy), 32'd0);
    checkOutput("flush_mid done", 32'(bus.done), 32'd0);
    checkOutput("flush_mid data_out", bus.data_out, prev);
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done) done_seen++;
    end
    checkOutput("flush_mid no late done", 32'(done_seen), 32'd0);
    applyStimulus("after_flush", 3'd2, 32'h0000_00F0, 5);
    waitDone("after_flush", 32'h0000_1E00, ref_latency(3'd2, 5), 0);
    prev = 32'h0000_1E00;

    // Flush on the same edge as the final step.
    applyStimulus("flush_last", 3'd3, 32'h0000_0001, 1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checkOutput("flush_last done", 32'(bus.done), 32'd0);
    checkOutput("flush_last busy", 32'(bus.busy), 32'd0);
    checkOutput("flush_last data_out", bus.data_out, prev);

    // Flush in IDLE blocks a simultaneous start.
    bus.start   = 1'b1;
    bus.flush   = 1'b1;
    bus.op      = 3'd0;
    bus.data_in = 32'h0000_00FF;
    bus.shamt   = 5'd1;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    checkOutput("flush_idle busy", 32'(bus.busy), 32'd0);
    tick();
    checkOutput("flush_idle done", 32'(bus.done), 32'd0);

    // Asynchronous reset mid-operation.
    applyStimulus("rst_mid", 3'd0, 32'hFFFF_FFFF, 29);
    tick();
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_mid done", 32'(bus.done), 32'd0);
    checkOutput("rst_mid data_out", bus.data_out, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    checkOutput("rst_mid stays idle", 32'(bus.busy), 32'd0);
    applyStimulus("after_rst", 3'd1, 32'h8000_0010, 7);
    waitDone("after_rst", 32'hFF00_0000, ref_latency(3'd1, 7), 0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      r_op   = 3'($urandom_range(0, 7));
      r_data = $urandom;
      r_sh   = int'($urandom_range(0, 31));
      applyStimulus($sformatf("rand%0d", i), r_op, r_data, r_sh);
      waitDone($sformatf("rand%0d", i), ref_shift(r_op, r_data, r_sh), ref_latency(r_op, r_sh), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
